spi_shifter: RTL

SPI_SHIFTER -- requirements
Module: spi_shifter

---
 rtl/pkg_ili9341.sv | 15 +
 rtl/spi_tick_gen.sv | 41 ++++
 rtl/spi_shifter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pkg_ili9341.sv
// ----------------------------------------------------------------------------
// pkg_ili9341
// Shared constants for the ILI9341 SPI path.
//   HIGH / LOW   : pin levels
//   NO_DATA      : value o_rx_data holds before any byte has been received
//   SPI_CLK_DIV  : default SCK half-period in system clock cycles
// ----------------------------------------------------------------------------
package pkg_ili9341;

    localparam logic            HIGH        = 1'b1;
    localparam logic            LOW         = 1'b0;
    localparam logic [7:0]      NO_DATA     = 8'h00;
    localparam int unsigned     SPI_CLK_DIV = 2;

endpackage

// File: rtl/spi_tick_gen.sv
// ----------------------------------------------------------------------------
// spi_tick_gen
// Phase counter for SCK timing. While enabled it counts system clock cycles
// and pulses o_tick on the last cycle of each CLK_DIV-cycle phase. A high
// stall input freezes the count and suppresses the tick.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   i_en     : count enable; counter is held at zero while low
//   i_stall  : freeze the counter (no tick while high)
//   o_tick   : one-cycle pulse marking the end of a phase
// ----------------------------------------------------------------------------
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_stall,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLK_DIV - 1));
    assign o_tick = i_en && !i_stall && w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
        end else if (!i_stall) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_shifter.sv
// ----------------------------------------------------------------------------
// spi_shifter
// Mode-0 (CPOL=0, CPHA=0) SPI byte shifter for an ILI9341 display.
// One byte per i_send request, MSB first, with simultaneous MISO capture.
// Ports:
//   clk, rst         : system clock, asynchronous active-low reset
//   i_send           : start request, only honoured while idle
//   i_data           : byte to transmit
//   i_dc, i_cs       : D/C and CS levels for this byte, latched with i_data
//   i_shift_dis      : stall the SCK phase counter while high
//   i_miso           : serial data from the display
//   o_command_sent   : one-cycle pulse when the byte completes
//   o_busy           : high whenever a transaction is in flight
//   o_rx_data        : byte captured during the last completed transaction
//   o_sck, o_mosi,
//   o_dc, o_cs       : SPI pins
// ----------------------------------------------------------------------------
module spi_shifter
    import pkg_ili9341::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_send,
    input  logic [DW-1:0] i_data,
    input  logic          i_dc,
    input  logic          i_cs,
    input  logic          i_shift_dis,
    input  logic          i_miso,
    output logic          o_command_sent,
    output logic          o_busy,
    output logic [DW-1:0] o_rx_data,
    output logic          o_sck,
    output logic          o_mosi,
    output logic          o_dc,
    output logic          o_cs
);

    localparam int unsigned BW = $clog2(DW);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShiftLo,
        StShiftHi,
        StHold,
        StDone
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_tx;
    logic [DW-1:0] r_rx_shift;
    logic [DW-1:0] r_rx_data;
    logic [BW-1:0] r_bit_cnt;
    logic          r_dc;
    logic          r_cs;
    logic          r_hi_first;
    logic          w_tick;
    logic          w_tick_en;

    assign w_tick_en = (r_state == StShiftLo) || (r_state == StShiftHi) || (r_state == StHold);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_tick_en),
        .i_stall (i_shift_dis),
        .o_tick  (w_tick)
    );

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:    if (i_send) w_next = StLoad;
            StLoad:    w_next = StShiftLo;
            StShiftLo: if (w_tick) w_next = StShiftHi;
            StShiftHi: if (w_tick) w_next = (r_bit_cnt == '0) ? StHold : StShiftLo;
            StHold:    if (w_tick) w_next = StDone;
            StDone:    w_next = StIdle;
            default:   w_next = StIdle;
        endcase
    end

    // Pin and status outputs, decoded from state so reset reaches the pins at once
    always_comb begin
        o_sck          = LOW;
        o_mosi         = LOW;
        o_dc           = HIGH;
        o_cs           = HIGH;
        o_busy         = 1'b1;
        o_command_sent = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
            end
            StShiftLo: begin
                o_mosi = r_tx[DW-1];
                o_dc   = r_dc;
                o_cs   = r_cs;
            end
            StShiftHi: begin
                o_sck  = HIGH;
                o_mosi = r_tx[DW-1];
                o_dc   = r_dc;
                o_cs   = r_cs;
            end
            StDone: begin
                o_command_sent = 1'b1;
                o_dc           = r_dc;
                o_cs           = r_cs;
            end
            default: begin
                o_dc = r_dc;
                o_cs = r_cs;
            end
        endcase
    end

    assign o_rx_data = r_rx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_tx       <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= DW'(NO_DATA);
            r_bit_cnt  <= '0;
            r_dc       <= HIGH;
            r_cs       <= HIGH;
            r_hi_first <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                StIdle: begin
                    // Latch on the accepting edge so D/C and CS are valid for the whole LOAD cycle
                    if (i_send) begin
                        r_tx      <= i_data;
                        r_dc      <= i_dc;
                        r_cs      <= i_cs;
                        r_bit_cnt <= BW'(DW - 1);
                    end
                end
                StShiftLo: begin
                    if (w_tick) r_hi_first <= 1'b1;
                end
                StShiftHi: begin
                    // MISO is taken once per bit, in the first high cycle, even if stalled
                    if (r_hi_first) begin
                        r_rx_shift <= {r_rx_shift[DW-2:0], i_miso};
                        r_hi_first <= 1'b0;
                    end
                    if (w_tick) begin
                        r_tx      <= {r_tx[DW-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                StHold: begin
                    if (w_tick) r_rx_data <= r_rx_shift;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
